// File: rtl/etherneco_synctimer_pkg.sv
// ============================================================================
// Module : etherneco_synctimer_pkg
// Brief  : Shared packet layout constants and types for the synctimer command.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package etherneco_synctimer_pkg;

    localparam int CMD_POS_CMD     = 0;
    localparam int CMD_POS_TIME    = 1;
    localparam int CMD_POS_OFFSET  = 9;
    localparam int OFFSET_BYTES    = 4;
    localparam int TIME_BYTES      = 8;

    localparam int CMD_BIT_CORRECT = 0;
    localparam int CMD_BIT_RENEW   = 1;

    typedef logic [TIME_BYTES-1:0][7:0]   time_pkt_t;
    typedef logic [OFFSET_BYTES-1:0][7:0] offset_pkt_t;

    function automatic int cmd_length(input int max_nodes);
        return CMD_POS_OFFSET + OFFSET_BYTES * max_nodes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/etherneco_synctimer_field_capture.sv
// ============================================================================
// Module : etherneco_synctimer_field_capture
// Brief  : Captures a multi-byte little-endian field from a payload byte stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module etherneco_synctimer_field_capture #(
    parameter int FIELD_POS = 1,
    parameter int NUM_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [15:0]            i_pos,
    input  logic [7:0]             i_data,
    output logic [NUM_BYTES*8-1:0] o_field
);

    logic [7:0] r_bytes [NUM_BYTES];

    generate
        for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bytes[b] <= '0;
                end else if (i_wr_en && (i_pos == 16'(FIELD_POS + b))) begin
                    r_bytes[b] <= i_data;
                end
            end
            assign o_field[b*8 +: 8] = r_bytes[b];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/etherneco_synctimer_slave_cmd_rx.sv
// ============================================================================
// Module : etherneco_synctimer_slave_cmd_rx
// Brief  : Slave synctimer command receiver; issues a compensated set/adjust.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module etherneco_synctimer_slave_cmd_rx
    import etherneco_synctimer_pkg::*;
#(
    parameter int TIMER_WIDTH  = 64,
    parameter int MAX_NODES    = 2,
    parameter int OFFSET_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             node_index,
    input  logic [TIMER_WIDTH-1:0] current_time,
    input  logic                   rx_start,
    input  logic                   rx_end,
    input  logic                   rx_error,
    input  logic [15:0]            payload_pos,
    input  logic [7:0]             payload_data,
    input  logic                   payload_valid,
    output logic [TIMER_WIDTH-1:0] set_time,
    output logic                   set_valid,
    output logic [TIMER_WIDTH-1:0] adjust_time,
    output logic                   adjust_valid,
    output logic [15:0]            drop_count
);

    localparam int         CMD_LEN     = cmd_length(MAX_NODES);
    localparam logic [15:0] c_CMD_LEN   = 16'(CMD_LEN);
    localparam logic [15:0] c_COUNT_MAX = 16'(CMD_LEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]             r_state;
    logic [TIMER_WIDTH-1:0] r_start_time;
    logic [15:0]            r_byte_count;
    logic                   r_err;
    logic [1:0]             r_cmd;
    logic [TIMER_WIDTH-1:0] r_result;
    logic [15:0]            r_drop_count;

    logic                   w_wr_en;
    logic [15:0]            w_off_pos;
    logic                   w_node_ok;
    time_pkt_t              w_time_pkt;
    offset_pkt_t            w_off_pkt;
    logic [31:0]            w_off_flat;
    logic [TIMER_WIDTH-1:0] w_base;

    assign w_wr_en   = (r_state == ST_RECV) && payload_valid && !rx_start &&
                       (payload_pos < c_CMD_LEN);
    assign w_node_ok = ({8'd0, node_index} < 16'(MAX_NODES));

    // Rebase the position so node i's slot lands on the node-0 offset window.
    assign w_off_pos = payload_pos - {6'd0, node_index, 2'b00};

    etherneco_synctimer_field_capture #(
        .FIELD_POS (CMD_POS_TIME),
        .NUM_BYTES (TIME_BYTES)
    ) u_time_cap (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_wr_en),
        .i_pos   (payload_pos),
        .i_data  (payload_data),
        .o_field (w_time_pkt)
    );

    etherneco_synctimer_field_capture #(
        .FIELD_POS (CMD_POS_OFFSET),
        .NUM_BYTES (OFFSET_BYTES)
    ) u_offset_cap (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_wr_en),
        .i_pos   (w_off_pos),
        .i_data  (payload_data),
        .o_field (w_off_pkt)
    );

    assign w_off_flat = w_off_pkt;
    assign w_base     = TIMER_WIDTH'(w_time_pkt) +
                        TIMER_WIDTH'(w_off_flat[OFFSET_WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_start_time <= '0;
            r_byte_count <= '0;
            r_err        <= 1'b0;
            r_cmd        <= '0;
            r_result     <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_start) begin
                        r_start_time <= current_time;
                        r_byte_count <= '0;
                        r_err        <= 1'b0;
                        r_state      <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (rx_start) begin
                        r_start_time <= current_time;
                        r_byte_count <= '0;
                        r_err        <= 1'b0;
                    end else begin
                        if (payload_valid && (r_byte_count != c_COUNT_MAX)) begin
                            r_byte_count <= r_byte_count + 16'd1;
                        end
                        if (payload_valid && (payload_pos == 16'(CMD_POS_CMD))) begin
                            r_cmd <= payload_data[1:0];
                        end
                        if (rx_error) begin
                            r_err <= 1'b1;
                        end
                        if (rx_end) begin
                            if (r_err || rx_error || (r_byte_count != c_CMD_LEN) || !w_node_ok) begin
                                r_state <= ST_IDLE;
                                if (r_drop_count != 16'hFFFF) begin
                                    r_drop_count <= r_drop_count + 16'd1;
                                end
                            end else begin
                                r_state <= ST_CALC;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    // +1 makes the elapsed time match the local time during OUT.
                    r_result <= w_base + (current_time - r_start_time + TIMER_WIDTH'(1));
                    r_state  <= ST_OUT;
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign set_valid    = (r_state == ST_OUT) && r_cmd[CMD_BIT_RENEW];
    assign adjust_valid = (r_state == ST_OUT) && !r_cmd[CMD_BIT_RENEW] && r_cmd[CMD_BIT_CORRECT];
    assign set_time     = r_result;
    assign adjust_time  = r_result;
    assign drop_count   = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_etherneco_synctimer_slave_cmd_rx.sv
// ============================================================================
// Module : tb_etherneco_synctimer_slave_cmd_rx
// Brief  : Directed self-checking bench for the synctimer slave receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_etherneco_synctimer_slave_cmd_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  node_index = 8'd1;
    logic [63:0] current_time = 64'd1000;
    logic        rx_start = 1'b0;
    logic        rx_end = 1'b0;
    logic        rx_error = 1'b0;
    logic [15:0] payload_pos = '0;
    logic [7:0]  payload_data = '0;
    logic        payload_valid = 1'b0;
    logic [63:0] set_time;
    logic        set_valid;
    logic [63:0] adjust_time;
    logic        adjust_valid;
    logic [15:0] drop_count;

    int checks = 0;
    int failures = 0;

    etherneco_synctimer_slave_cmd_rx #(
        .TIMER_WIDTH  (64),
        .MAX_NODES    (2),
        .OFFSET_WIDTH (24)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .node_index    (node_index),
        .current_time  (current_time),
        .rx_start      (rx_start),
        .rx_end        (rx_end),
        .rx_error      (rx_error),
        .payload_pos   (payload_pos),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .set_time      (set_time),
        .set_valid     (set_valid),
        .adjust_time   (adjust_time),
        .adjust_valid  (adjust_valid),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) current_time <= current_time + 64'd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One packet: rx_start at c=0, bytes at c=1..nbytes, rx_end at c=20.
    // Expected pulse is observed at c=22 (two cycles after rx_end).
    task automatic send_pkt(input string tag, input logic [7:0] cmd, input logic [63:0] mtime,
                            input logic [31:0] off0, input logic [31:0] off1, input int nbytes,
                            input int err_cyc, input bit rst_calc, input bit exp_set,
                            input bit exp_adj, input logic [63:0] exp_val);
        logic [7:0] pkt [17];
        pkt[0] = cmd;
        for (int k = 0; k < 8; k++) pkt[1+k] = mtime[8*k +: 8];
        for (int k = 0; k < 4; k++) begin
            pkt[9+k]  = off0[8*k +: 8];
            pkt[13+k] = off1[8*k +: 8];
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 21) check({tag, "_pre"}, {62'd0, set_valid, adjust_valid}, 64'd0);
            if (c == 22) begin
                check({tag, "_set_valid"}, {63'd0, set_valid}, {63'd0, exp_set});
                check({tag, "_adj_valid"}, {63'd0, adjust_valid}, {63'd0, exp_adj});
                if (exp_set) check({tag, "_set_time"}, set_time, exp_val);
                if (exp_adj) check({tag, "_adj_time"}, adjust_time, exp_val);
            end
            if (c == 23) check({tag, "_post"}, {62'd0, set_valid, adjust_valid}, 64'd0);
            rx_start      = (c == 0);
            rx_end        = (c == 20);
            rx_error      = (err_cyc != 0) && (c == err_cyc);
            rst           = rst_calc && (c == 21);
            payload_valid = (c >= 1) && (c <= nbytes);
            payload_pos   = 16'(c - 1);
            payload_data  = 8'h00;
            if (c >= 1 && c <= nbytes && c <= 17) payload_data = pkt[c-1];
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_set_valid", {63'd0, set_valid}, 64'd0);
        check("reset_adj_valid", {63'd0, adjust_valid}, 64'd0);
        check("reset_drop", {48'd0, drop_count}, 64'd0);
        rst = 1'b0;

        send_pkt("renew", 8'h02, 64'h1_0000, 32'h10, 32'h20, 17, 0, 0, 1, 0, 64'h1_0036);
        send_pkt("correct", 8'h01, 64'h1_0000, 32'h10, 32'h20, 17, 0, 0, 0, 1, 64'h1_0036);
        send_pkt("both", 8'h03, 64'h1_0000, 32'h10, 32'h20, 17, 0, 0, 1, 0, 64'h1_0036);

        send_pkt("err_mid", 8'h02, 64'h1_0000, 32'h10, 32'h20, 17, 8, 0, 0, 0, 64'd0);
        check("drop_err_mid", {48'd0, drop_count}, 64'd1);
        send_pkt("err_end", 8'h02, 64'h1_0000, 32'h10, 32'h20, 17, 20, 0, 0, 0, 64'd0);
        check("drop_err_end", {48'd0, drop_count}, 64'd2);
        send_pkt("clean_after", 8'h01, 64'h1_0000, 32'h10, 32'h20, 17, 0, 0, 0, 1, 64'h1_0036);
        check("drop_clean", {48'd0, drop_count}, 64'd2);

        send_pkt("trunc", 8'h02, 64'h1_0000, 32'h10, 32'h20, 16, 0, 0, 0, 0, 64'd0);
        check("drop_trunc", {48'd0, drop_count}, 64'd3);
        node_index = 8'd2;
        send_pkt("node2", 8'h02, 64'h1_0000, 32'h10, 32'h20, 17, 0, 0, 0, 0, 64'd0);
        check("drop_node2", {48'd0, drop_count}, 64'd4);
        node_index = 8'd1;

        send_pkt("wrap", 8'h02, 64'hFFFF_FFFF_FFFF_FFF0, 32'h10, 32'h20, 17, 0, 0, 1, 0, 64'h26);
        send_pkt("off_mask", 8'h01, 64'h1_0000, 32'h10, 32'hFF12_3456, 17, 0, 0, 0, 1, 64'h13_346C);
        node_index = 8'd0;
        send_pkt("node0", 8'h02, 64'h1_0000, 32'h10, 32'h20, 17, 0, 0, 1, 0, 64'h1_0026);
        node_index = 8'd1;
        send_pkt("cmd0", 8'h00, 64'h1_0000, 32'h10, 32'h20, 17, 0, 0, 0, 0, 64'd0);
        check("drop_cmd0", {48'd0, drop_count}, 64'd4);

        // Partial packet, then a restart that carries the full packet.
        @(negedge clk);
        rx_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rx_start      = 1'b0;
            payload_valid = 1'b1;
            payload_pos   = 16'(k);
            payload_data  = 8'hAA;
        end
        send_pkt("restart", 8'h02, 64'h1_0000, 32'h10, 32'h20, 17, 0, 0, 1, 0, 64'h1_0036);
        check("drop_restart", {48'd0, drop_count}, 64'd4);

        send_pkt("rst_calc", 8'h02, 64'h1_0000, 32'h10, 32'h20, 17, 0, 1, 0, 0, 64'd0);
        check("drop_after_rst", {48'd0, drop_count}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
